chunked_adder: RTL

CHUNKED_ADDER -- requirements
Module: chunked_adder

---
 rtl/chunked_adder_if.sv | 24 ++
 rtl/chunked_adder.sv | 80 ++++++++
 2 files changed

// File: rtl/chunked_adder_if.sv
// chunked_adder_if: operand/result handshake bundle for the chunked adder
interface chunked_adder_if #(parameter int WIDTH = 16);
  logic             clear_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             sub_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             ovf_o;
  logic             zero_o;
  modport master (
    output clear_i, valid_i, a_i, b_i, cin_i, sub_i, ready_i,
    input  ready_o, valid_o, sum_o, cout_o, ovf_o, zero_o
  );
  modport slave (
    input  clear_i, valid_i, a_i, b_i, cin_i, sub_i, ready_i,
    output ready_o, valid_o, sum_o, cout_o, ovf_o, zero_o
  );
endinterface

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/subtract, CHUNK bits per cycle, valid/ready on both sides
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic           clk_i,
  input logic           rst_ni,
  chunked_adder_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q, acc_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q, zero_q, last;
  logic [CHUNK:0]   part;
  // Operands shift right each cycle so the active chunk is always the low CHUNK bits;
  // the accumulator fills from the top so it is aligned after the final chunk.
  assign part  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  assign acc_d = (acc_q >> CHUNK) | (WIDTH'(part[CHUNK-1:0]) << (WIDTH - CHUNK));
  assign last  = cnt_q == CW'(NCH - 1);
  assign bus.ready_o = state_q == IDLE;
  assign bus.valid_o = state_q == DONE;
  assign bus.sum_o   = sum_q;
  assign bus.cout_o  = cout_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.zero_o  = zero_q;
  always_comb begin
    state_d = state_q;
    if (bus.clear_i) state_d = IDLE;
    else if (state_q == IDLE && bus.valid_i) state_d = BUSY;
    else if (state_q == BUSY && last) state_d = DONE;
    else if (state_q == DONE && bus.ready_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (bus.clear_i) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (state_q == IDLE && bus.valid_i) begin
      a_q <= bus.a_i;
      b_q <= bus.sub_i ? ~bus.b_i : bus.b_i;
      carry_q <= bus.sub_i | bus.cin_i;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == BUSY) begin
      a_q <= a_q >> CHUNK;
      b_q <= b_q >> CHUNK;
      acc_q <= acc_d;
      carry_q <= part[CHUNK];
      cnt_q <= last ? cnt_q : cnt_q + CW'(1);
      // Results publish only on the last chunk; held values stay intact during BUSY.
      if (last) begin
        sum_q <= acc_d;
        cout_q <= part[CHUNK];
        ovf_q <= part[CHUNK] ^ (a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ part[CHUNK-1]);
        zero_q <= acc_d == '0;
      end
    end
endmodule
